// File: rtl/spin_speed_pkg.sv
// Shared spin-speed tables: speed ladder, per-programme default/min/max
// ladder indices and the wash-mode encoding.
package spin_speed_pkg;

    localparam int unsigned SPEED_W    = 11;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned MODE_W     = 3;
    localparam int unsigned NUM_MODES  = 8;
    localparam int unsigned LADDER_LEN = 8;

    typedef logic [SPEED_W-1:0] speed_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [MODE_W-1:0] {
        COTTON      = 3'd0,
        SYNTHETICS  = 3'd1,
        DELICATES   = 3'd2,
        WOOL        = 3'd3,
        QUICK       = 3'd4,
        MIXED       = 3'd5,
        RINSE_SPIN  = 3'd6,
        DRAIN_ONLY  = 3'd7
    } wash_mode_e;

    // Ladder indices 0..6 are real speeds; entry 7 pads the 3-bit index
    // space and is never reached because no mode has max above 6.
    localparam speed_t SPEED_LADDER [LADDER_LEN] = '{
        11'd0, 11'd400, 11'd600, 11'd800, 11'd1000, 11'd1200, 11'd1400, 11'd0
    };

    localparam idx_t MODE_DEF_IDX [NUM_MODES] = '{
        3'd5, 3'd3, 3'd2, 3'd1, 3'd3, 3'd4, 3'd4, 3'd0
    };

    localparam idx_t MODE_MIN_IDX [NUM_MODES] = '{
        3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0
    };

    localparam idx_t MODE_MAX_IDX [NUM_MODES] = '{
        3'd6, 3'd4, 3'd3, 3'd3, 3'd5, 3'd6, 3'd6, 3'd0
    };

endpackage

// File: rtl/spin_inc_edge.sv
// Rising-edge detector for the increment button. The history bit resets
// high so a button held through reset never produces a pulse.
module spin_inc_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic hist_q;

    // History samples the input every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= din;
        end
    end

    // Single-cycle pulse, valid in the same cycle the input first goes high
    assign rise_c = din & ~hist_q;

endmodule

// File: rtl/spin_speed_incrementor_lut.sv
// Drum spin-speed selector: loads the programme default from the LUT on
// reset release or mode change, then steps through the speed ladder on
// increment rising edges. Define SPIN_SPEED_WRAP_EN to wrap from max back
// to the programme minimum; otherwise the index saturates at max.
module spin_speed_incrementor_lut
    import spin_speed_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [MODE_W-1:0] wash_mode,
    input  logic              increment,
    output logic [SPEED_W-1:0] selected_spin_speed
);

    logic              inc_rise_c;
    idx_t              idx_q;
    idx_t              idx_d;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] mode_d;
    logic              load_pending_q;
    logic              load_pending_d;
    speed_t            speed_q;
    idx_t              def_idx_c;
    idx_t              max_idx_c;
`ifdef SPIN_SPEED_WRAP_EN
    idx_t              min_idx_c;
`endif

    spin_inc_edge u_edge (
        .clk    (clk),
        .rst_n  (reset),
        .din    (increment),
        .rise_c (inc_rise_c)
    );

    // LUT decode: default follows the live input, limits follow the stored mode
    assign def_idx_c = MODE_DEF_IDX[wash_mode];
    assign max_idx_c = MODE_MAX_IDX[mode_q];
`ifdef SPIN_SPEED_WRAP_EN
    assign min_idx_c = MODE_MIN_IDX[mode_q];
`endif

    // Next-state: pending/mode load beats increment, increment beats hold
    always_comb begin
        idx_d          = idx_q;
        mode_d         = mode_q;
        load_pending_d = load_pending_q;
        if (load_pending_q || (wash_mode != mode_q)) begin
            idx_d          = def_idx_c;
            mode_d         = wash_mode;
            load_pending_d = 1'b0;
        end else if (inc_rise_c) begin
            if (idx_q < max_idx_c) begin
                idx_d = idx_q + IDX_W'(1);
            end else begin
`ifdef SPIN_SPEED_WRAP_EN
                idx_d = min_idx_c;
`else
                idx_d = idx_q;
`endif
            end
        end
    end

    // State and output registers; output tracks the index written this edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q          <= '0;
            mode_q         <= '0;
            load_pending_q <= 1'b1;
            speed_q        <= '0;
        end else begin
            idx_q          <= idx_d;
            mode_q         <= mode_d;
            load_pending_q <= load_pending_d;
            speed_q        <= SPEED_LADDER[idx_d];
        end
    end

    assign selected_spin_speed = speed_q;

endmodule

// File: tb/tb_spin_speed_incrementor_lut.sv
// Bench for spin_speed_incrementor_lut: table of {mode, increment,
// expected speed} vectors fed through a scoreboard queue, plus hand-written
// reset sequences. Expectations follow SPIN_SPEED_WRAP_EN if defined.
module tb_spin_speed_incrementor_lut;

`ifdef SPIN_SPEED_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  wash_mode = 3'd0;
    logic        increment = 1'b0;
    logic [10:0] selected_spin_speed;

    int total = 0;
    int bad = 0;
    int vec_id = 0;

    typedef struct {
        int          id;
        logic [10:0] exp;
    } sb_t;

    typedef struct {
        logic [2:0]  mode;
        logic        inc;
        logic [10:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t tbl[$];

    always #5 clk = ~clk;

    spin_speed_incrementor_lut dut (
        .clk                 (clk),
        .reset               (reset),
        .wash_mode           (wash_mode),
        .increment           (increment),
        .selected_spin_speed (selected_spin_speed)
    );

    task automatic check(input string name, input int id,
                         input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %0d expected %0d (t=%0t)", name, id, act, exp, $time);
        end
    endtask

    // Scoreboard: one expected value consumed per clock after the edge
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("scoreboard", mon_e.id, selected_spin_speed, mon_e.exp);
        end
    end

    task automatic apply(input logic [2:0] m, input logic inc, input logic [10:0] exp);
        sb_t e;
        wash_mode = m;
        increment = inc;
        e.id  = vec_id;
        e.exp = exp;
        vec_id++;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mk(input logic [2:0] m, input logic inc, input int exp);
        vec_t v;
        v.mode = m;
        v.inc  = inc;
        v.exp  = 11'(exp);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int defaults [8] = '{1200, 800, 600, 400, 800, 1000, 1000, 0};

        // Wool stepping from default 400 (min 0, max 3)
        tbl.push_back(mk(3'd3, 1'b0, 400));
        tbl.push_back(mk(3'd3, 1'b1, 600));
        tbl.push_back(mk(3'd3, 1'b0, 600));
        tbl.push_back(mk(3'd3, 1'b1, 800));
        tbl.push_back(mk(3'd3, 1'b0, 800));
        tbl.push_back(mk(3'd3, 1'b1, WRAP ? 0 : 800));
        tbl.push_back(mk(3'd3, 1'b0, WRAP ? 0 : 800));
        tbl.push_back(mk(3'd3, 1'b1, WRAP ? 400 : 800));
        tbl.push_back(mk(3'd3, 1'b0, WRAP ? 400 : 800));
        tbl.push_back(mk(3'd3, 1'b1, WRAP ? 600 : 800));
        tbl.push_back(mk(3'd3, 1'b0, WRAP ? 600 : 800));
        // Synthetics from 800 (min 1, max 4)
        tbl.push_back(mk(3'd1, 1'b0, 800));
        tbl.push_back(mk(3'd1, 1'b1, 1000));
        tbl.push_back(mk(3'd1, 1'b0, 1000));
        tbl.push_back(mk(3'd1, 1'b1, WRAP ? 400 : 1000));
        tbl.push_back(mk(3'd1, 1'b0, WRAP ? 400 : 1000));
        tbl.push_back(mk(3'd1, 1'b1, WRAP ? 600 : 1000));
        tbl.push_back(mk(3'd1, 1'b0, WRAP ? 600 : 1000));
        // Cotton with increment held high for 10 cycles: one step only
        tbl.push_back(mk(3'd0, 1'b0, 1200));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(3'd0, 1'b1, 1400));
        tbl.push_back(mk(3'd0, 1'b0, 1400));
        // Mode change 3->5 coinciding with increment edge: load wins
        tbl.push_back(mk(3'd3, 1'b0, 400));
        tbl.push_back(mk(3'd5, 1'b1, 1000));
        tbl.push_back(mk(3'd5, 1'b1, 1000));
        tbl.push_back(mk(3'd5, 1'b0, 1000));
        tbl.push_back(mk(3'd5, 1'b1, 1200));
        tbl.push_back(mk(3'd5, 1'b0, 1200));

        // Reset then default load for every programme
        for (int m = 0; m < 8; m++) begin
            reset = 1'b0;
            #1;
            check("reset_async", m, selected_spin_speed, 11'd0);
            wash_mode = 3'(m);
            increment = 1'b0;
            @(posedge clk);
            #2;
            check("reset_held", m, selected_spin_speed, 11'd0);
            reset = 1'b1;
            apply(3'(m), 1'b0, 11'(defaults[m]));
            apply(3'(m), 1'b0, 11'(defaults[m]));
        end

        // Table-driven main sequence (starts from drain-only, output 0)
        foreach (tbl[i]) apply(tbl[i].mode, tbl[i].inc, tbl[i].exp);

        // Asynchronous reset between edges drops output at once
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midreset_async", 0, selected_spin_speed, 11'd0);
        wash_mode = 3'd7;
        @(posedge clk);
        #2;
        reset = 1'b1;
        apply(3'd7, 1'b0, 11'd0);
        apply(3'd7, 1'b1, 11'd0);
        apply(3'd7, 1'b0, 11'd0);
        apply(3'd7, 1'b1, 11'd0);
        apply(3'd7, 1'b0, 11'd0);

        // Increment held through reset must not step after release
        #3;
        reset = 1'b0;
        increment = 1'b1;
        wash_mode = 3'd6;
        #1;
        check("heldreset_async", 0, selected_spin_speed, 11'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        apply(3'd6, 1'b1, 11'd1000);
        apply(3'd6, 1'b1, 11'd1000);
        apply(3'd6, 1'b0, 11'd1000);
        apply(3'd6, 1'b1, 11'd1200);
        apply(3'd6, 1'b0, 11'd1200);

        @(posedge clk);
        #2;
        check("sb_drain", 0, 11'(sb_q.size()), 11'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
